// File: rtl/cpu_run_monitor.sv
// cpu_run_monitor: sequences the cpu reset, counts run cycles and judges pass/timeout from the status lights.
// Optional heartbeat output and HB_SHIFT parameter: define CPU_RUN_MONITOR_HEARTBEAT_EN.
module cpu_run_monitor #(
    parameter int NUM_LIGHTS    = 1,
    parameter int CNT_W         = 32,
    parameter int RESET_CYCLES  = 4,
    parameter int STABLE_CYCLES = 8
`ifdef CPU_RUN_MONITOR_HEARTBEAT_EN
    ,
    parameter int HB_SHIFT      = 24
`endif
) (
    input  logic                  clock,
    input  logic                  clrn,
    input  logic                  start,
    input  logic [CNT_W-1:0]      timeout_limit,
    input  logic [NUM_LIGHTS-1:0] expect_mask,
    input  logic [NUM_LIGHTS-1:0] light,
    output logic                  cpu_clrn,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic                  timed_out,
    output logic [CNT_W-1:0]      cycle_count
`ifdef CPU_RUN_MONITOR_HEARTBEAT_EN
    ,
    output logic                  heartbeat
`endif
);
    localparam int RW = RESET_CYCLES > 1 ? $clog2(RESET_CYCLES) : 1;
    localparam int SW = STABLE_CYCLES > 1 ? $clog2(STABLE_CYCLES) : 1;

    typedef enum logic [1:0] {IDLE, RESET, RUN, DONE} state_t;

    state_t                state;
    logic [RW-1:0]         rst_cnt;
    logic [SW-1:0]         stable_cnt;
    logic [NUM_LIGHTS-1:0] mask_q;
    logic [CNT_W-1:0]      limit_q;
    logic [CNT_W-1:0]      cnt_inc;
    logic                  match;
    logic                  stable_hit;
    logic                  limit_hit;

    // Completion conditions evaluated on every RUN cycle; a stable match outranks the timeout
    always_comb begin
        cnt_inc    = cycle_count + CNT_W'(1);
        match      = light == mask_q;
        stable_hit = match && stable_cnt == SW'(STABLE_CYCLES - 1);
        limit_hit  = limit_q != '0 && cnt_inc == limit_q;
    end

    // Run sequencer: IDLE/DONE wait for start, RESET holds the cpu, RUN watches the lights
    always_ff @(posedge clock or negedge clrn) begin
        if (!clrn) begin
            state       <= IDLE;
            cpu_clrn    <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            pass        <= 1'b0;
            timed_out   <= 1'b0;
            cycle_count <= '0;
            rst_cnt     <= '0;
            stable_cnt  <= '0;
            mask_q      <= '0;
            limit_q     <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state       <= RESET;
                        mask_q      <= expect_mask;
                        limit_q     <= timeout_limit;
                        cpu_clrn    <= 1'b0;
                        busy        <= 1'b1;
                        done        <= 1'b0;
                        pass        <= 1'b0;
                        timed_out   <= 1'b0;
                        cycle_count <= '0;
                        rst_cnt     <= '0;
                        stable_cnt  <= '0;
                    end
                end
                RESET: begin
                    rst_cnt <= rst_cnt + 1'b1;
                    if (rst_cnt == RW'(RESET_CYCLES - 1)) begin
                        state    <= RUN;
                        cpu_clrn <= 1'b1;
                    end
                end
                RUN: begin
                    cycle_count <= &cycle_count ? cycle_count : cnt_inc;
                    stable_cnt  <= match ? stable_cnt + 1'b1 : '0;
                    if (stable_hit || limit_hit) begin
                        state     <= DONE;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        pass      <= stable_hit;
                        timed_out <= !stable_hit;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef CPU_RUN_MONITOR_HEARTBEAT_EN
    // Toggle on each falling edge of cycle_count[HB_SHIFT-1] while running, i.e. every 2^HB_SHIFT cycles
    always_ff @(posedge clock or negedge clrn) begin
        if (!clrn)
            heartbeat <= 1'b0;
        else if (state == RUN && !(&cycle_count) && cycle_count[HB_SHIFT-1] && !cnt_inc[HB_SHIFT-1])
            heartbeat <= ~heartbeat;
    end
`endif

endmodule
